// File: rtl/param_serializer_if.sv
// Handshake and serial-line bundle for param_serializer: the producer side
// drives in_valid/in_data, the serializer drives everything else.
interface param_serializer_if #(
  parameter int DATA_W = 10
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              serial_out;
  logic              serial_valid;
  logic              frame_start;
  logic              busy;

  modport master (
    output in_valid, in_data,
    input  in_ready, serial_out, serial_valid, frame_start, busy
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, serial_out, serial_valid, frame_start, busy
  );
endinterface

// File: rtl/param_serializer.sv
// Parallel-to-serial converter with a one-word holding buffer for gap-free frames.
// Optional trailing parity bit enabled by defining SERIALIZER_PARITY_EN.
module param_serializer #(
  parameter int DATA_W     = 10,
  parameter bit MSB_FIRST  = 1'b1,
  parameter bit IDLE_LEVEL = 1'b0,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic                clk,
  input  logic                reset,
  param_serializer_if.slave   bus
);
  localparam int CW = (DATA_W > 2) ? $clog2(DATA_W) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
`ifdef SERIALIZER_PARITY_EN
  localparam logic [1:0] S_PARITY = 2'd2;
`endif

  logic [1:0]        r_state;
  logic [DATA_W-1:0] r_shreg;
  logic [CW-1:0]     r_cnt;
  logic [DATA_W-1:0] r_hold;
  logic              r_hold_full;
  logic              r_sout;
  logic              r_svalid;
  logic              r_fstart;
  logic              r_busy;
`ifdef SERIALIZER_PARITY_EN
  logic              r_par;
`else
  logic              w_unused_parity;
  assign w_unused_parity = &{1'b0, PARITY_ODD};
`endif

  logic              w_accept;
  logic              w_last;
  logic              w_load;
  logic              w_hold_full_n;
  logic [1:0]        w_state_n;
  logic              w_hold_edge;
  logic              w_sh_edge;
  logic [DATA_W-1:0] w_hold_shift;
  logic [DATA_W-1:0] w_sh_shift;

  // Shift direction is fixed at elaboration; the bit leaving the edge is the one sent.
  generate
    if (MSB_FIRST) begin : g_msb
      assign w_hold_edge  = r_hold[DATA_W-1];
      assign w_sh_edge    = r_shreg[DATA_W-1];
      assign w_hold_shift = {r_hold[DATA_W-2:0], 1'b0};
      assign w_sh_shift   = {r_shreg[DATA_W-2:0], 1'b0};
    end else begin : g_lsb
      assign w_hold_edge  = r_hold[0];
      assign w_sh_edge    = r_shreg[0];
      assign w_hold_shift = {1'b0, r_hold[DATA_W-1:1]};
      assign w_sh_shift   = {1'b0, r_shreg[DATA_W-1:1]};
    end
  endgenerate

  assign w_accept = bus.in_valid && !r_hold_full;
  assign w_last   = (r_cnt == CW'(DATA_W - 1));

  always_comb begin
    w_state_n = r_state;
    w_load    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_hold_full) begin
          w_state_n = S_SHIFT;
          w_load    = 1'b1;
        end
      end
      S_SHIFT: begin
        if (w_last) begin
`ifdef SERIALIZER_PARITY_EN
          w_state_n = S_PARITY;
`else
          // Frame end: reload straight from the buffer so no idle cycle appears.
          w_state_n = r_hold_full ? S_SHIFT : S_IDLE;
          w_load    = r_hold_full;
`endif
        end
      end
`ifdef SERIALIZER_PARITY_EN
      S_PARITY: begin
        w_state_n = r_hold_full ? S_SHIFT : S_IDLE;
        w_load    = r_hold_full;
      end
`endif
      default: w_state_n = S_IDLE;
    endcase
  end

  assign w_hold_full_n = w_load ? 1'b0 : (r_hold_full | w_accept);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_shreg     <= '0;
      r_cnt       <= '0;
      r_hold      <= '0;
      r_hold_full <= 1'b0;
      r_sout      <= IDLE_LEVEL;
      r_svalid    <= 1'b0;
      r_fstart    <= 1'b0;
      r_busy      <= 1'b0;
`ifdef SERIALIZER_PARITY_EN
      r_par       <= 1'b0;
`endif
    end else begin
      r_state     <= w_state_n;
      r_hold_full <= w_hold_full_n;
      r_busy      <= (w_state_n != S_IDLE) || w_hold_full_n;
      r_fstart    <= 1'b0;
      if (w_accept)
        r_hold <= bus.in_data;

      if (w_load) begin
        r_shreg  <= w_hold_shift;
        r_sout   <= w_hold_edge;
        r_svalid <= 1'b1;
        r_fstart <= 1'b1;
        r_cnt    <= '0;
`ifdef SERIALIZER_PARITY_EN
        r_par    <= (^r_hold) ^ PARITY_ODD;
`endif
      end else if (r_state == S_SHIFT && !w_last) begin
        r_shreg  <= w_sh_shift;
        r_sout   <= w_sh_edge;
        r_svalid <= 1'b1;
        r_cnt    <= r_cnt + 1'b1;
`ifdef SERIALIZER_PARITY_EN
      end else if (r_state == S_SHIFT) begin
        r_sout   <= r_par;
        r_svalid <= 1'b1;
`endif
      end else begin
        r_sout   <= IDLE_LEVEL;
        r_svalid <= 1'b0;
      end
    end
  end

  assign bus.in_ready     = !r_hold_full;
  assign bus.serial_out   = r_sout;
  assign bus.serial_valid = r_svalid;
  assign bus.frame_start  = r_fstart;
  assign bus.busy         = r_busy;
endmodule

// File: tb/tb_param_serializer.sv
// Bench for param_serializer: two instances (MSB-first/idle-low, LSB-first/idle-high)
// share one stimulus and are checked every cycle against a frame-schedule model.
module tb_param_serializer;
  localparam int DW = 10;
`ifdef SERIALIZER_PARITY_EN
  localparam int FRAME = DW + 1;
`else
  localparam int FRAME = DW;
`endif

  logic          clk = 1'b0;
  logic          trst = 1'b1;
  logic          tv = 1'b0;
  logic [DW-1:0] td = '0;

  always #5 clk = ~clk;

  param_serializer_if #(.DATA_W(DW)) busA ();
  param_serializer_if #(.DATA_W(DW)) busB ();
  assign busA.in_valid = tv;
  assign busA.in_data  = td;
  assign busB.in_valid = tv;
  assign busB.in_data  = td;

  param_serializer #(.DATA_W(DW), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0), .PARITY_ODD(1'b0))
    dutA (.clk(clk), .reset(trst), .bus(busA));
  param_serializer #(.DATA_W(DW), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b1), .PARITY_ODD(1'b1))
    dutB (.clk(clk), .reset(trst), .bus(busB));

  int nvec = 0;
  int nerr = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Model: each accepted word is a frame occupying [start, start+FRAME) in edge time.
  typedef struct { logic [DW-1:0] w; int s; } frame_t;
  frame_t q[$];
  int     cyc    = 0;
  int     last_s = -1000;
  bit     m_acc;

  logic [15:0] capA, capB;
  int          nfsA, nfsB, nvalA;

  function automatic logic exp_bit(logic [DW-1:0] w, int k, bit msb, bit podd);
    if (k >= DW) return (^w) ^ podd;
    return msb ? w[DW-1-k] : w[k];
  endfunction

  task automatic model_edge(input logic v, input logic [DW-1:0] d, input logic r);
    bit rdy;
    int s;
    cyc++;
    rdy = 1'b1;
    foreach (q[i]) if (q[i].s > cyc - 1) rdy = 1'b0;
    m_acc = 1'b0;
    if (r) begin
      q.delete();
      last_s = -1000;
    end else if (v && rdy) begin
      s = (cyc + 1 > last_s + FRAME) ? cyc + 1 : last_s + FRAME;
      q.push_back('{w: d, s: s});
      last_s = s;
      m_acc  = 1'b1;
    end
    while (q.size() > 0 && q[0].s + FRAME <= cyc) void'(q.pop_front());
  endtask

  task automatic check_one(input string n, input bit msb, input bit idle, input bit podd,
                           input logic so, input logic sv, input logic fs,
                           input logic bz, input logic rd);
    logic e_bit, e_val, e_fs, e_rdy;
    e_bit = idle; e_val = 1'b0; e_fs = 1'b0; e_rdy = 1'b1;
    foreach (q[i]) begin
      if (q[i].s <= cyc && cyc < q[i].s + FRAME) begin
        e_val = 1'b1;
        e_fs  = (cyc == q[i].s);
        e_bit = exp_bit(q[i].w, cyc - q[i].s, msb, podd);
      end
      if (q[i].s > cyc) e_rdy = 1'b0;
    end
    chk({n, ".serial_out"},   32'(so), 32'(e_bit));
    chk({n, ".serial_valid"}, 32'(sv), 32'(e_val));
    chk({n, ".frame_start"},  32'(fs), 32'(e_fs));
    chk({n, ".busy"},         32'(bz), 32'(q.size() > 0));
    chk({n, ".in_ready"},     32'(rd), 32'(e_rdy));
  endtask

  task automatic step(input logic v, input logic [DW-1:0] d, input logic r);
    tv = v; td = d; trst = r;
    @(posedge clk);
    model_edge(v, d, r);
    #1;
    check_one("A", 1'b1, 1'b0, 1'b0, busA.serial_out, busA.serial_valid,
              busA.frame_start, busA.busy, busA.in_ready);
    check_one("B", 1'b0, 1'b1, 1'b1, busB.serial_out, busB.serial_valid,
              busB.frame_start, busB.busy, busB.in_ready);
    if (busA.serial_valid === 1'b1) begin capA = {capA[14:0], busA.serial_out}; nvalA++; end
    if (busB.serial_valid === 1'b1) capB = {capB[14:0], busB.serial_out};
    if (busA.frame_start === 1'b1) nfsA++;
    if (busB.frame_start === 1'b1) nfsB++;
  endtask

  // Holds in_valid with the word until the model accepts it, bounded.
  task automatic send(input logic [DW-1:0] w);
    int n = 0;
    do begin
      step(1'b1, w, 1'b0);
      n++;
    end while (!m_acc && n < 100);
    if (!m_acc) chk("send.timeout", 32'(n), 32'(0));
  endtask

  task automatic clr_cap();
    capA = '0; capB = '0; nfsA = 0; nfsB = 0; nvalA = 0;
  endtask

  initial begin
    logic [15:0] expA, expB;
    clr_cap();
    repeat (3) step(1'b0, '0, 1'b1);
    // Long idle after reset, including a stray-free idle line on the idle-high copy.
    repeat (100) step(1'b0, '0, 1'b0);

    // Single frame, both bit orders.
    clr_cap();
    send(10'b1010110001);
    repeat (FRAME + 4) step(1'b0, '0, 1'b0);
`ifdef SERIALIZER_PARITY_EN
    expA = 16'({10'b1010110001, 1'b1});
    expB = 16'({10'b1000110101, 1'b0});
`else
    expA = 16'(10'b1010110001);
    expB = 16'(10'b1000110101);
`endif
    chk("t1.A.stream", 32'(capA & 16'((1 << FRAME) - 1)), 32'(expA));
    chk("t2.B.stream", 32'(capB & 16'((1 << FRAME) - 1)), 32'(expB));
    chk("t1.A.nfs", 32'(nfsA), 32'd1);
    chk("t2.B.nfs", 32'(nfsB), 32'd1);

    // Back-to-back with in_valid held high.
    clr_cap();
    send(10'b1010110001);
    send(10'b0101011010);
    repeat (2 * FRAME + 4) step(1'b0, '0, 1'b0);
    chk("t3.nvalid", 32'(nvalA), 32'(2 * FRAME));
    chk("t3.nfs", 32'(nfsA), 32'd2);

    // Reset one cycle after the 5th bit, with a second word held.
    send(10'b1010100101);
    send(10'b1111100000);
    repeat (3) step(1'b0, '0, 1'b0);
    step(1'b1, 10'b0011001100, 1'b1);
    chk("t4.serial_valid", 32'(busA.serial_valid), 32'd0);
    chk("t4.busy", 32'(busA.busy), 32'd0);
    chk("t4.in_ready", 32'(busA.in_ready), 32'd1);
    clr_cap();
    repeat (2 * FRAME) step(1'b0, '0, 1'b0);
    chk("t4.no_bits", 32'(nvalA), 32'd0);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 1500; i++)
      step($urandom_range(0, 3) != 0, DW'($urandom), $urandom_range(0, 199) == 0);
    repeat (2 * FRAME + 2) step(1'b0, '0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
